// File: rtl/sync_combiner.sv
// Merges narrow sync pulses and 8N1 UART characters onto one idle-high line.
// Each sync pulse is followed by its 32-bit index as four little-endian bytes.
module sync_combiner #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_LEN     = 100,
    parameter int GUARD        = 868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sync_req,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        sync_line,
    output logic        sync_deferred,
    output logic        sync_drop,
    output logic [31:0] sync_cnt,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam int MAX_A = (CLKS_PER_BIT > SYNC_LEN) ? CLKS_PER_BIT : SYNC_LEN;
    localparam int MAX_D = (MAX_A > GUARD) ? MAX_A : GUARD;
    localparam int CW    = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [31:0]   idx_q, idx_d;
    logic [2:0]    left_q, left_d;
    logic          pend_q, pend_d;
    logic [31:0]   sync_cnt_q, sync_cnt_d;
    logic          line_q, line_d;
    logic          def_q, def_d;
    logic          drop_q, drop_d;
    logic          in_char;

    // Handshake: a user byte transfers on a clock edge where tx_valid and
    // tx_ready are both high; the source holds tx_data stable until then.
    assign tx_ready = rstn && (state_q == S_IDLE) && !pend_q && !sync_req && (left_q == 3'd0);
    assign in_char  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        left_d     = left_q;
        pend_d     = pend_q;
        sync_cnt_d = sync_cnt_q;
        line_d     = line_q;
        def_d      = 1'b0;
        drop_d     = 1'b0;

        if (sync_req) begin
            if ((state_q == S_SYNC) || (state_q == S_GUARD)) begin
                drop_d = 1'b1;
            end else if (in_char) begin
                if (pend_q) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                    def_d  = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sync_req || pend_q) begin
                    state_d    = S_SYNC;
                    line_d     = 1'b0;
                    cnt_d      = SYNC_LAST;
                    idx_d      = sync_cnt_q;
                    sync_cnt_d = sync_cnt_q + 32'd1;
                    left_d     = 3'd4;
                    pend_d     = 1'b0;
                    // Unsent index bytes of the previous sync are overwritten here.
                    drop_d     = (sync_req && pend_q) || (left_q != 3'd0);
                end else if (left_q != 3'd0) begin
                    state_d = S_START;
                    line_d  = 1'b0;
                    cnt_d   = BIT_LAST;
                    shift_d = idx_q[7:0];
                    idx_d   = {8'h00, idx_q[31:8]};
                    left_d  = left_q - 3'd1;
                end else if (tx_valid && tx_ready) begin
                    state_d = S_START;
                    line_d  = 1'b0;
                    cnt_d   = BIT_LAST;
                    shift_d = tx_data;
                end
            end
            S_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = S_GUARD;
                    line_d  = 1'b1;
                    cnt_d   = GUARD_LAST;
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) state_d = S_IDLE;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    line_d  = shift_q[0];
                    cnt_d   = BIT_LAST;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        line_d  = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        line_d  = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == '0) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            idx_q      <= 32'd0;
            left_q     <= 3'd0;
            pend_q     <= 1'b0;
            sync_cnt_q <= 32'd0;
            line_q     <= 1'b1;
            def_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            left_q     <= left_d;
            pend_q     <= pend_d;
            sync_cnt_q <= sync_cnt_d;
            line_q     <= line_d;
            def_q      <= def_d;
            drop_q     <= drop_d;
        end
    end

    assign sync_line     = line_q;
    assign sync_deferred = def_q;
    assign sync_drop     = drop_q;
    assign sync_cnt      = sync_cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_sync_combiner.sv
// Bench for sync_combiner: a line decoder turns sync_line back into sync/byte
// events, which are compared against an event list built from the line rules.
module tb_sync_combiner;

    localparam int CPB = 8;
    localparam int SL  = 3;
    localparam int GD  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sync_req = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        sync_line;
    logic        sync_deferred;
    logic        sync_drop;
    logic [31:0] sync_cnt;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    sync_combiner #(.CLKS_PER_BIT(CPB), .SYNC_LEN(SL), .GUARD(GD)) dut (
        .clk(clk),
        .rstn(rstn),
        .sync_req(sync_req),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .sync_line(sync_line),
        .sync_deferred(sync_deferred),
        .sync_drop(sync_drop),
        .sync_cnt(sync_cnt),
        .state_dbg(state_dbg)
    );

    int cyc = 0;
    int n_def = 0;
    int n_drop = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sync_deferred) n_def <= n_def + 1;
        if (sync_drop) n_drop <= n_drop + 1;
    end

    // Line decoder: a low shorter than half a bit is a sync pulse, else a UART frame.
    logic [8:0] obs_q[$];
    int         obs_t[$];
    int         obs_w[$];
    int         mode = 0;
    int         lowcnt = 0;
    int         t0 = 0;
    logic [7:0] rx = 8'h00;

    always @(negedge clk) begin
        if (!rstn) begin
            mode <= 0;
        end else begin
            case (mode)
                0: if (!sync_line) begin
                    mode <= 1;
                    lowcnt <= 1;
                    t0 <= cyc;
                end
                1: if (sync_line) begin
                    obs_q.push_back(9'h100);
                    obs_t.push_back(t0);
                    obs_w.push_back(lowcnt);
                    mode <= 0;
                end else begin
                    lowcnt <= lowcnt + 1;
                    if (lowcnt + 1 >= CPB / 2) mode <= 2;
                end
                2: begin
                    if (((cyc - t0) % CPB) == CPB / 2 && (cyc - t0) > CPB && (cyc - t0) < 9 * CPB)
                        rx <= {sync_line, rx[7:1]};
                    if ((cyc - t0) == 9 * CPB + CPB / 2) begin
                        obs_q.push_back({1'b0, rx});
                        obs_t.push_back(t0);
                        obs_w.push_back(int'(sync_line));
                        mode <= sync_line ? 0 : 3;
                    end
                end
                default: if (sync_line) mode <= 0;
            endcase
        end
    end

    logic [8:0]  exp_q[$];
    int          last_t[$];
    logic [31:0] model_cnt;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // A sync puts one pulse on the line followed by the first nb bytes of its index.
    function automatic void model_sync(input int nb);
        exp_q.push_back(9'h100);
        for (int i = 0; i < nb; i++) exp_q.push_back({1'b0, model_cnt[8*i +: 8]});
        model_cnt = model_cnt + 32'd1;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sync();
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g;
        g = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("handshake in time", g < 3000, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back({1'b0, b});
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (obs_q.size() < exp_q.size() && g < 5000) begin
            @(negedge clk);
            g++;
        end
        wait_n(200);
        chk({tag, " event count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, " event"}, obs_q[i], exp_q[i]);
            if (exp_q[i] == 9'h100) chk({tag, " sync width"}, obs_w[i], SL);
            else chk({tag, " stop bit"}, obs_w[i], 1);
        end
        last_t = obs_t;
        obs_q.delete();
        obs_t.delete();
        obs_w.delete();
        exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p0;
        int g;
        model_cnt = 32'd0;

        wait_n(3);
        chk("reset line", sync_line, 1);
        chk("reset tx_ready", tx_ready, 0);
        chk("reset deferred", sync_deferred, 0);
        chk("reset drop", sync_drop, 0);
        chk("reset sync_cnt", sync_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready after reset", tx_ready, 1);

        // Plain sync: pulse, guard, four index bytes.
        pulse_sync();
        model_sync(4);
        chk("sync_cnt after sync", sync_cnt, model_cnt);
        chk("ready blocked by index", tx_ready, 0);
        drain("sync0");
        chk("sync to first index", last_t[1] - last_t[0], SL + GD + 1);
        chk("index byte period", last_t[2] - last_t[1], 10 * CPB + 1);

        // Back-to-back user bytes.
        push_byte(8'hA5);
        push_byte(8'h3C);
        for (int k = 0; k < 3; k++) push_byte(8'($urandom_range(0, 255)));
        drain("user");
        chk("user byte period", last_t[1] - last_t[0], 10 * CPB + 1);
        chk("user byte period 2", last_t[4] - last_t[3], 10 * CPB + 1);

        // Sync requested during data bit 4 is deferred to the end of the character.
        d0 = n_def;
        p0 = n_drop;
        push_byte(8'($urandom_range(0, 255)));
        wait_n(40);
        pulse_sync();
        model_sync(4);
        push_byte(8'($urandom_range(0, 255)));
        wait_n(2);
        chk("deferred pulses", n_def - d0, 1);
        drain("deferred");
        chk("deferred sync start", last_t[1] - last_t[0], 10 * CPB + 1);
        chk("deferred drops", n_drop - p0, 0);

        // Two requests in one character plus one in the guard time.
        d0 = n_def;
        p0 = n_drop;
        push_byte(8'($urandom_range(0, 255)));
        wait_n(20);
        pulse_sync();
        model_sync(4);
        wait_n(10);
        pulse_sync();
        g = 0;
        while (obs_q.size() < 2 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        pulse_sync();
        wait_n(3);
        chk("double deferred", n_def - d0, 1);
        chk("double drops", n_drop - p0, 2);
        drain("double");

        // Deferred sync overruns the index bytes of the previous sync.
        d0 = n_def;
        p0 = n_drop;
        pulse_sync();
        model_sync(1);
        wait_n(30);
        pulse_sync();
        model_sync(4);
        drain("overrun");
        chk("overrun deferred", n_def - d0, 1);
        chk("overrun drop", n_drop - p0, 1);

        // Counter wrap from all-ones.
        force dut.sync_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.sync_cnt_q;
        @(negedge clk);
        chk("preloaded sync_cnt", sync_cnt, 32'hFFFF_FFFF);
        model_cnt = 32'hFFFF_FFFF;
        pulse_sync();
        model_sync(4);
        chk("sync_cnt wrapped", sync_cnt, model_cnt);
        drain("wrap");
        pulse_sync();
        model_sync(4);
        drain("post wrap");

        // Reset in the middle of a character.
        push_byte(8'($urandom_range(0, 255)));
        wait_n(30);
        #2 rstn = 1'b0;
        #1;
        chk("mid reset line", sync_line, 1);
        chk("mid reset tx_ready", tx_ready, 0);
        chk("mid reset sync_cnt", sync_cnt, 0);
        chk("mid reset deferred", sync_deferred, 0);
        chk("mid reset drop", sync_drop, 0);
        wait_n(3);
        rstn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
        obs_w.delete();
        model_cnt = 32'd0;
        @(negedge clk);
        pulse_sync();
        model_sync(4);
        drain("after reset");
        chk("sync_cnt after reset sync", sync_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
